// File: rtl/microstep_pkg.sv
// Shared types and constants for the microstepper phase scheduler.
//   PHASE_W/IDX_W/MAG_W : electrical phase, ROM index and magnitude widths
//   quadrant_t          : top two phase bits
//   sched_state_t       : scheduler FSM states
//   coil_drive_t        : magnitude + polarity pair driven to the PWM stage
//   scale_mag()         : (mag * scale) >> 8, used only when
//                         COSINE_SCHED_SCALE_EN is defined
package microstep_pkg;
  localparam int PHASE_W = 8;
  localparam int IDX_W   = 6;
  localparam int MAG_W   = 8;

  typedef logic [1:0] quadrant_t;

  typedef enum logic [1:0] {IDLE, LOOK_A, LOOK_B, CAP_B} sched_state_t;

  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic             neg;
  } coil_drive_t;

  // Upper byte of an 8x8 product: full scale 255 gives slightly below unity.
  function automatic logic [MAG_W-1:0] scale_mag(input logic [MAG_W-1:0] m,
                                                 input logic [MAG_W-1:0] s);
    logic [2*MAG_W-1:0] p;
    p = m * s;
    return p[2*MAG_W-1:MAG_W];
  endfunction
endpackage

// File: rtl/cosine.sv
// Quarter-wave cosine ROM, round(255*cos(idx*pi/128)), one-cycle registered read.
// The output register is not reset: it is only consumed after a lookup.
//   clk : clock
//   idx : 6-bit index
//   mag : 8-bit magnitude, valid one cycle after idx
module cosine
  import microstep_pkg::*;
(
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  output logic [MAG_W-1:0] mag
);
  always_ff @(posedge clk) begin
    unique case (idx)
      6'd0:  mag <= 8'd255; 6'd1:  mag <= 8'd255; 6'd2:  mag <= 8'd255; 6'd3:  mag <= 8'd254;
      6'd4:  mag <= 8'd254; 6'd5:  mag <= 8'd253; 6'd6:  mag <= 8'd252; 6'd7:  mag <= 8'd251;
      6'd8:  mag <= 8'd250; 6'd9:  mag <= 8'd249; 6'd10: mag <= 8'd247; 6'd11: mag <= 8'd246;
      6'd12: mag <= 8'd244; 6'd13: mag <= 8'd242; 6'd14: mag <= 8'd240; 6'd15: mag <= 8'd238;
      6'd16: mag <= 8'd236; 6'd17: mag <= 8'd233; 6'd18: mag <= 8'd231; 6'd19: mag <= 8'd228;
      6'd20: mag <= 8'd225; 6'd21: mag <= 8'd222; 6'd22: mag <= 8'd219; 6'd23: mag <= 8'd215;
      6'd24: mag <= 8'd212; 6'd25: mag <= 8'd208; 6'd26: mag <= 8'd205; 6'd27: mag <= 8'd201;
      6'd28: mag <= 8'd197; 6'd29: mag <= 8'd193; 6'd30: mag <= 8'd189; 6'd31: mag <= 8'd185;
      6'd32: mag <= 8'd180; 6'd33: mag <= 8'd176; 6'd34: mag <= 8'd171; 6'd35: mag <= 8'd167;
      6'd36: mag <= 8'd162; 6'd37: mag <= 8'd157; 6'd38: mag <= 8'd152; 6'd39: mag <= 8'd147;
      6'd40: mag <= 8'd142; 6'd41: mag <= 8'd136; 6'd42: mag <= 8'd131; 6'd43: mag <= 8'd126;
      6'd44: mag <= 8'd120; 6'd45: mag <= 8'd115; 6'd46: mag <= 8'd109; 6'd47: mag <= 8'd103;
      6'd48: mag <= 8'd98;  6'd49: mag <= 8'd92;  6'd50: mag <= 8'd86;  6'd51: mag <= 8'd80;
      6'd52: mag <= 8'd74;  6'd53: mag <= 8'd68;  6'd54: mag <= 8'd62;  6'd55: mag <= 8'd56;
      6'd56: mag <= 8'd50;  6'd57: mag <= 8'd44;  6'd58: mag <= 8'd37;  6'd59: mag <= 8'd31;
      6'd60: mag <= 8'd25;  6'd61: mag <= 8'd19;  6'd62: mag <= 8'd13;  6'd63: mag <= 8'd6;
      default: mag <= 8'd0;
    endcase
  end
endmodule

// File: rtl/quadrant_fold.sv
// Folds an electrical phase onto the cosine quarter-wave.
//   p   : electrical phase, [7:6] quadrant, [5:0] index
//   idx : quarter-wave ROM index (mirrored in odd quadrants)
//   neg : polarity, 1 = negative half of the cosine
module quadrant_fold
  import microstep_pkg::*;
(
  input  logic [PHASE_W-1:0] p,
  output logic [IDX_W-1:0]   idx,
  output logic               neg
);
  quadrant_t        q;
  logic [IDX_W-1:0] i;

  assign q = p[PHASE_W-1:IDX_W];
  assign i = p[IDX_W-1:0];

  always_comb begin
    idx = i;
    neg = 1'b0;
    unique case (q)
      2'd0: begin idx = i;  neg = 1'b0; end
      2'd1: begin idx = ~i; neg = 1'b1; end
      2'd2: begin idx = i;  neg = 1'b1; end
      2'd3: begin idx = ~i; neg = 1'b0; end
      default: ;
    endcase
  end
endmodule

// File: rtl/cosine_phase_scheduler.sv
// Shares one cosine quarter-wave ROM between the two microstepper coils.
// Coil A = cos(phase), coil B = cos(phase - B_OFFSET). Fixed 4-cycle latency,
// one request per 4 cycles, both coils always update together.
// Optional: COSINE_SCHED_SCALE_EN adds current_scale; each magnitude becomes
// (rom * scale) >> 8 with scale sampled when the request is accepted.
//   clk, reset      : clock, asynchronous active-high reset
//   phase_req/phase : request strobe and 8-bit electrical phase
//   phase_ready     : high in IDLE; requests while low are dropped
//   coil_{a,b}_mag  : coil magnitudes
//   coil_{a,b}_neg  : coil polarities, 1 = negative
//   out_valid       : one-cycle pulse when both coils were updated
//   current_scale   : (optional) magnitude scale
module cosine_phase_scheduler
  import microstep_pkg::*;
#(
  parameter logic [PHASE_W-1:0] B_OFFSET = 8'd64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               phase_req,
  input  logic [PHASE_W-1:0] phase,
  output logic               phase_ready,
  output logic [MAG_W-1:0]   coil_a_mag,
  output logic               coil_a_neg,
  output logic [MAG_W-1:0]   coil_b_mag,
  output logic               coil_b_neg,
`ifdef COSINE_SCHED_SCALE_EN
  input  logic [MAG_W-1:0]   current_scale,
`endif
  output logic               out_valid
);
  sched_state_t       state, state_nxt;
  logic [PHASE_W-1:0] phase_q, phase_b;
  logic [IDX_W-1:0]   idx_a, idx_b, rom_idx;
  logic               neg_a, neg_b;
  logic [MAG_W-1:0]   rom_mag, mag_cap, hold_a;
  coil_drive_t        coil_a, coil_b;
  logic               accept;

  assign accept  = phase_req & phase_ready;
  assign phase_b = phase_q - B_OFFSET;  // 8-bit modular wrap

  quadrant_fold u_fold_a (.p(phase_q), .idx(idx_a), .neg(neg_a));
  quadrant_fold u_fold_b (.p(phase_b), .idx(idx_b), .neg(neg_b));

  cosine u_rom (.clk(clk), .idx(rom_idx), .mag(rom_mag));

`ifdef COSINE_SCHED_SCALE_EN
  logic [MAG_W-1:0] scale_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       scale_q <= '0;
    else if (accept) scale_q <= current_scale;
  end
  assign mag_cap = scale_mag(rom_mag, scale_q);
`else
  assign mag_cap = rom_mag;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = LOOK_A;
      LOOK_A:  state_nxt = LOOK_B;
      LOOK_B:  state_nxt = CAP_B;
      CAP_B:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs. The ROM is addressed with the B index outside
  // LOOK_A; the read in IDLE/CAP_B is simply ignored.
  always_comb begin
    phase_ready = (state == IDLE);
    rom_idx     = (state == LOOK_A) ? idx_a : idx_b;
  end

  // Datapath: A is parked in hold_a until B arrives so both coils commit at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= '0;
      hold_a    <= '0;
      coil_a    <= '0;
      coil_b    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept)          phase_q <= phase;
      if (state == LOOK_B) hold_a  <= mag_cap;
      if (state == CAP_B) begin
        coil_a    <= '{mag: hold_a,  neg: neg_a};
        coil_b    <= '{mag: mag_cap, neg: neg_b};
        out_valid <= 1'b1;
      end
    end
  end

  assign coil_a_mag = coil_a.mag;
  assign coil_a_neg = coil_a.neg;
  assign coil_b_mag = coil_b.mag;
  assign coil_b_neg = coil_b.neg;
endmodule

// File: tb/tb_cosine_phase_scheduler.sv
module tb_cosine_phase_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       phase_req;
  logic [7:0] phase;
  logic       phase_ready;
  logic [7:0] coil_a_mag, coil_b_mag;
  logic       coil_a_neg, coil_b_neg;
  logic       out_valid;
`ifdef COSINE_SCHED_SCALE_EN
  logic [7:0] current_scale;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cosine_phase_scheduler dut (
    .clk(clk), .reset(reset), .phase_req(phase_req), .phase(phase),
    .phase_ready(phase_ready),
    .coil_a_mag(coil_a_mag), .coil_a_neg(coil_a_neg),
    .coil_b_mag(coil_b_mag), .coil_b_neg(coil_b_neg),
`ifdef COSINE_SCHED_SCALE_EN
    .current_scale(current_scale),
`endif
    .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected magnitude for a raw ROM value under the build's scaling (scale 255 when enabled).
  function automatic logic [7:0] em(input logic [7:0] v);
`ifdef COSINE_SCHED_SCALE_EN
    logic [15:0] p;
    p = v * 8'd255;
    return p[15:8];
`else
    return v;
`endif
  endfunction

  // Issue one request from idle and check latency, outputs and pulse width.
  task automatic do_req(input string tag, input logic [7:0] p,
                        input logic [7:0] am, input logic an,
                        input logic [7:0] bm, input logic bn);
    int cnt;
    cnt = 0;
    @(negedge clk);
    phase_req = 1'b1;
    phase     = p;
    do begin
      @(negedge clk);
      phase_req = 1'b0;
      cnt++;
    end while (!out_valid && cnt < 10);
    chk({tag, "_lat"},   cnt, 4);
    chk({tag, "_amag"},  coil_a_mag, am);
    chk({tag, "_aneg"},  coil_a_neg, an);
    chk({tag, "_bmag"},  coil_b_mag, bm);
    chk({tag, "_bneg"},  coil_b_neg, bn);
    chk({tag, "_rdy"},   phase_ready, 1);
    @(negedge clk);
    chk({tag, "_pulse"}, out_valid, 0);
  endtask

  initial begin
    int nval, pos;
    reset     = 1'b1;
    phase_req = 1'b0;
    phase     = 8'd0;
`ifdef COSINE_SCHED_SCALE_EN
    current_scale = 8'd255;
`endif
    #12;
    chk("rst_amag", coil_a_mag, 0);
    chk("rst_bmag", coil_b_mag, 0);
    chk("rst_negs", {coil_a_neg, coil_b_neg}, 0);
    chk("rst_vld",  out_valid, 0);
    chk("rst_rdy",  phase_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    do_req("p0",   8'd0,   em(255), 0, em(6),   0);
    do_req("p64",  8'd64,  em(6),   1, em(255), 0);
    do_req("p128", 8'd128, em(255), 1, em(6),   1);
    do_req("p32",  8'd32,  em(180), 0, em(185), 0);
    do_req("p255", 8'd255, em(255), 0, em(6),   1);

    // Back-to-back with a dropped request while busy.
    @(negedge clk); phase_req = 1'b1; phase = 8'd0;
    @(negedge clk); phase_req = 1'b0;
    chk("busy_rdy", phase_ready, 0);
    @(negedge clk); phase_req = 1'b1; phase = 8'd128;   // LOOK_B: must be ignored
    @(negedge clk); phase_req = 1'b0;
    @(negedge clk);
    chk("b2b_v1",   out_valid, 1);
    chk("b2b_a1",   coil_a_mag, em(255));
    phase_req = 1'b1; phase = 8'd64;                     // in the valid cycle
    nval = 0; pos = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      phase_req = 1'b0;
      if (out_valid) begin
        nval++;
        pos = c;
        chk("b2b_a2", coil_a_mag, em(6));
        chk("b2b_a2n", coil_a_neg, 1);
        chk("b2b_b2", coil_b_mag, em(255));
      end
    end
    chk("b2b_nval", nval, 1);
    chk("b2b_gap",  pos, 4);

    // Reset while in LOOK_B.
    @(negedge clk); phase_req = 1'b1; phase = 8'd128;
    @(negedge clk); phase_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    #1;
    chk("mid_amag", coil_a_mag, 0);
    chk("mid_aneg", coil_a_neg, 0);
    chk("mid_bmag", coil_b_mag, 0);
    chk("mid_vld",  out_valid, 0);
    chk("mid_rdy",  phase_ready, 1);
    @(negedge clk); reset = 1'b0;
    chk("mid_rdy2", phase_ready, 1);
    nval = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) nval++;
    end
    chk("mid_nopulse", nval, 0);
    do_req("post", 8'd32, em(180), 0, em(185), 0);

`ifdef COSINE_SCHED_SCALE_EN
    current_scale = 8'd128;
    do_req("sc128", 8'd0, 8'd127, 0, 8'd3, 0);
    // Scale changed right after acceptance must not touch the in-flight result.
    @(negedge clk); phase_req = 1'b1; phase = 8'd64; current_scale = 8'd128;
    @(negedge clk); phase_req = 1'b0; current_scale = 8'd255;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("scmid_v",  out_valid, 1);
    chk("scmid_a",  coil_a_mag, 8'd3);
    chk("scmid_b",  coil_b_mag, 8'd127);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
